// File: rtl/shiftreg_framer.sv
`default_nettype none
// ============================================================================
// Module   : shiftreg_framer
// Brief    : Serial-to-parallel shift register with MSB-first frame tracking,
//            parallel load / serial-out, and idle-timeout abort of partial
//            frames. Shift strobe and data come from the input conditioner.
// Revision : 1.0 - initial release
// ============================================================================
module shiftreg_framer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     peripheralClkEdge,
    input  logic                     serialDataIn,
    input  logic                     parallelLoad,
    input  logic [WIDTH-1:0]         parallelDataIn,
    output logic [WIDTH-1:0]         parallelDataOut,
    output logic                     serialDataOut,
    output logic [$clog2(WIDTH)-1:0] bitCount,
    output logic                     frameDone,
    output logic                     frameError
);

    localparam int c_cnt_w  = $clog2(WIDTH);
    // Idle counter needs to hold 0..TIMEOUT; keep one bit when disabled.
    localparam int c_idle_w = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit c_to_en  = (TIMEOUT != 0);

    localparam logic [c_cnt_w-1:0]  c_last_bit = c_cnt_w'(WIDTH - 1);
    localparam logic [c_idle_w-1:0] c_idle_max = c_idle_w'(TIMEOUT);

    logic [WIDTH-1:0]    r_data;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_idle_w-1:0] r_idle;
    logic                r_done;
    logic                r_err;

    logic [WIDTH-1:0]    w_data_nxt;
    logic [c_cnt_w-1:0]  w_cnt_nxt;
    logic [c_idle_w-1:0] w_idle_nxt;
    logic                w_done_nxt;
    logic                w_err_nxt;

    // Next-state selection: load beats shift, shift beats idle timeout.
    always_comb begin
        w_data_nxt = r_data;
        w_cnt_nxt  = r_cnt;
        w_idle_nxt = r_idle;
        w_done_nxt = 1'b0;
        w_err_nxt  = 1'b0;
        if (parallelLoad) begin
            // A coincident strobe is dropped; the loaded word starts a fresh frame.
            w_data_nxt = parallelDataIn;
            w_cnt_nxt  = '0;
            w_idle_nxt = '0;
        end else if (peripheralClkEdge) begin
            w_data_nxt = {r_data[WIDTH-2:0], serialDataIn};
            w_idle_nxt = '0;
            if (r_cnt == c_last_bit) begin
                w_cnt_nxt  = '0;
                w_done_nxt = 1'b1;
            end else begin
                w_cnt_nxt  = r_cnt + c_cnt_w'(1);
            end
        end else if (c_to_en && (r_idle != c_idle_max)) begin
            // Saturating idle count; abort fires only on the edge it first
            // reaches the limit, and only if a frame is partially assembled.
            // Register contents are deliberately kept for inspection.
            w_idle_nxt = r_idle + c_idle_w'(1);
            if ((w_idle_nxt == c_idle_max) && (r_cnt != '0)) begin
                w_cnt_nxt = '0;
                w_err_nxt = 1'b1;
            end
        end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= '0;
            r_cnt  <= '0;
            r_idle <= '0;
            r_done <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_data <= w_data_nxt;
            r_cnt  <= w_cnt_nxt;
            r_idle <= w_idle_nxt;
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
        end
    end

    assign parallelDataOut = r_data;
    assign serialDataOut   = r_data[WIDTH-1];
    assign bitCount        = r_cnt;
    assign frameDone       = r_done;
    assign frameError      = r_err;

endmodule
`default_nettype wire

// File: tb/tb_shiftreg_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_shiftreg_framer
// Brief    : Self-checking bench for shiftreg_framer (WIDTH=8, TIMEOUT=4)
//            with directed scenarios and a randomized run against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shiftreg_framer;

    localparam int W = 8;
    localparam int T = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         peripheralClkEdge;
    logic         serialDataIn;
    logic         parallelLoad;
    logic [W-1:0] parallelDataIn;
    logic [W-1:0] parallelDataOut;
    logic         serialDataOut;
    logic [2:0]   bitCount;
    logic         frameDone;
    logic         frameError;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state, kept as plain integers.
    int m_reg, m_cnt, m_idle;
    int m_done, m_err;

    shiftreg_framer #(.WIDTH(W), .TIMEOUT(T)) dut (
        .clk              (clk),
        .reset            (reset),
        .peripheralClkEdge(peripheralClkEdge),
        .serialDataIn     (serialDataIn),
        .parallelLoad     (parallelLoad),
        .parallelDataIn   (parallelDataIn),
        .parallelDataOut  (parallelDataOut),
        .serialDataOut    (serialDataOut),
        .bitCount         (bitCount),
        .frameDone        (frameDone),
        .frameError       (frameError)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_reset();
        m_reg = 0; m_cnt = 0; m_idle = 0; m_done = 0; m_err = 0;
    endtask

    // Drive one clock's worth of inputs, advance model, leave time at edge+1.
    task automatic cycle(input bit ld, input logic [7:0] din, input bit stb, input bit sdi);
        parallelLoad      = ld;
        parallelDataIn    = din;
        peripheralClkEdge = stb;
        serialDataIn      = sdi;
        @(posedge clk);
        #1;
        m_done = 0;
        m_err  = 0;
        if (ld) begin
            m_reg = din; m_cnt = 0; m_idle = 0;
        end else if (stb) begin
            m_reg  = (m_reg * 2 + int'(sdi)) % 256;
            m_idle = 0;
            m_cnt  = m_cnt + 1;
            if (m_cnt == W) begin
                m_cnt = 0; m_done = 1;
            end
        end else if (m_idle < T) begin
            m_idle = m_idle + 1;
            if (m_idle == T && m_cnt != 0) begin
                m_cnt = 0; m_err = 1;
            end
        end
        parallelLoad      = 1'b0;
        peripheralClkEdge = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] bits;
        // Power-on reset state.
        n_cmp++;
        if ({parallelDataOut, bitCount, serialDataOut, frameDone, frameError} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_initial: got data=%h cnt=%0d so=%b done=%b err=%b required all 0",
                     parallelDataOut, bitCount, serialDataOut, frameDone, frameError);
        end
        // Build register=A5, bitCount=3: load 14, then shift 1,0,1.
        bits = 8'b101;
        cycle(1, 8'h14, 0, 0);
        for (int i = 2; i >= 0; i--) cycle(0, 8'h00, 1, bits[i]);
        n_cmp++;
        if (parallelDataOut !== 8'hA5 || bitCount !== 3'd3) begin
            n_bad++;
            $display("FAIL reset_setup: got data=%h cnt=%0d required A5/3", parallelDataOut, bitCount);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({parallelDataOut, bitCount, serialDataOut, frameDone, frameError} !== 13'd0) begin
            n_bad++;
            $display("FAIL reset_async: got data=%h cnt=%0d so=%b done=%b err=%b required all 0",
                     parallelDataOut, bitCount, serialDataOut, frameDone, frameError);
        end
        #1 reset = 1'b0;
        model_reset();
    endtask

    task automatic test_frame();
        logic [7:0] bits;
        bits = 8'hA5;
        cycle(1, 8'h00, 0, 0);
        for (int i = 7; i >= 0; i--) begin
            cycle(0, 8'h00, 1, bits[i]);
            if (i != 0) begin
                n_cmp++;
                if (frameDone !== 1'b0) begin
                    n_bad++;
                    $display("FAIL frame_early_done: strobe %0d got %b required 0", 8 - i, frameDone);
                end
            end
        end
        n_cmp++;
        if (parallelDataOut !== 8'hA5 || bitCount !== 3'd0 || frameDone !== 1'b1) begin
            n_bad++;
            $display("FAIL frame_done: got data=%h cnt=%0d done=%b required A5/0/1",
                     parallelDataOut, bitCount, frameDone);
        end
        cycle(0, 8'h00, 0, 0);
        n_cmp++;
        if (frameDone !== 1'b0 || parallelDataOut !== 8'hA5) begin
            n_bad++;
            $display("FAIL frame_pulse_end: got done=%b data=%h required 0/A5", frameDone, parallelDataOut);
        end
    endtask

    task automatic test_collision();
        cycle(1, 8'h3C, 1, 1);
        n_cmp++;
        if (parallelDataOut !== 8'h3C || bitCount !== 3'd0) begin
            n_bad++;
            $display("FAIL collision_load: got data=%h cnt=%0d required 3C/0", parallelDataOut, bitCount);
        end
        cycle(0, 8'h00, 1, 1);
        n_cmp++;
        if (parallelDataOut !== 8'h79 || serialDataOut !== 1'b0 || bitCount !== 3'd1) begin
            n_bad++;
            $display("FAIL collision_shift: got data=%h so=%b cnt=%0d required 79/0/1",
                     parallelDataOut, serialDataOut, bitCount);
        end
    endtask

    task automatic test_timeout();
        cycle(1, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 8'h00, 1, 1'(i));
        for (int k = 1; k <= 6; k++) begin
            cycle(0, 8'h00, 0, 0);
            n_cmp++;
            if (frameError !== (k == T) || bitCount !== ((k >= T) ? 3'd0 : 3'd3)) begin
                n_bad++;
                $display("FAIL timeout_partial: idle edge %0d got err=%b cnt=%0d required %b/%0d",
                         k, frameError, bitCount, (k == T), (k >= T) ? 0 : 3);
            end
        end
        n_cmp++;
        if (parallelDataOut !== 8'h02) begin
            n_bad++;
            $display("FAIL timeout_keep_data: got %h required 02", parallelDataOut);
        end
        cycle(1, 8'h00, 0, 0);
        for (int k = 1; k <= 6; k++) begin
            cycle(0, 8'h00, 0, 0);
            n_cmp++;
            if (frameError !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout_empty: idle edge %0d got err=%b required 0", k, frameError);
            end
        end
    endtask

    task automatic test_back_to_back();
        cycle(1, 8'h00, 0, 0);
        for (int i = 1; i <= 16; i++) begin
            cycle(0, 8'h00, 1, (i <= 8));
            n_cmp++;
            if (frameDone !== (i == 8 || i == 16)) begin
                n_bad++;
                $display("FAIL b2b_done: strobe %0d got %b required %b", i, frameDone, (i == 8 || i == 16));
            end
            if (i == 8 || i == 16) begin
                n_cmp++;
                if (parallelDataOut !== ((i == 8) ? 8'hFF : 8'h00)) begin
                    n_bad++;
                    $display("FAIL b2b_data: strobe %0d got %h required %h",
                             i, parallelDataOut, (i == 8) ? 8'hFF : 8'h00);
                end
            end
        end
    endtask

    task automatic test_serial_out();
        logic [8:0] exp_seq;
        exp_seq = 9'b1_0000_0010; // index 8 first: 1,0,0,0,0,0,0,1,0
        cycle(1, 8'h81, 0, 0);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) cycle(0, 8'h00, 1, 0);
            n_cmp++;
            if (serialDataOut !== exp_seq[8-i]) begin
                n_bad++;
                $display("FAIL serial_out: step %0d got %b required %b", i, serialDataOut, exp_seq[8-i]);
            end
        end
    endtask

    task automatic test_random();
        int r;
        bit ld, stb;
        for (int n = 0; n < 3000; n++) begin
            r   = $urandom_range(0, 99);
            ld  = (r < 4);
            stb = (r < 60);
            cycle(ld, 8'($urandom), stb, 1'($urandom));
            n_cmp++;
            if (parallelDataOut !== 8'(m_reg) || bitCount !== 3'(m_cnt) ||
                serialDataOut !== 1'(m_reg / 128) || frameDone !== 1'(m_done) ||
                frameError !== 1'(m_err)) begin
                n_bad++;
                $display("FAIL random: cycle %0d got data=%h cnt=%0d so=%b done=%b err=%b required %h/%0d/%0d/%0d/%0d",
                         n, parallelDataOut, bitCount, serialDataOut, frameDone, frameError,
                         m_reg, m_cnt, m_reg / 128, m_done, m_err);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        peripheralClkEdge = 1'b0;
        serialDataIn = 1'b0;
        parallelLoad = 1'b0;
        parallelDataIn = '0;
        model_reset();
        #2;
        @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_frame();
        test_collision();
        test_timeout();
        test_back_to_back();
        test_serial_out();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shiftreg_framer.md
# shiftreg_framer

Serial-to-parallel shift register with frame tracking, placed directly downstream of the input conditioner. It consumes the conditioner's `conditioned` level as serial data and its `positiveedge` pulse as the shift strobe. It assembles `WIDTH`-bit frames MSB-first and flags each completed frame. It also supports parallel load with serial-out for the transmit direction, and aborts stale partial frames after an idle timeout.

## Interface
- `WIDTH`, default 8: shift register and frame width in bits, must be ≥2.
- `TIMEOUT`, default 255: idle `clk` cycles without a shift strobe before a partial frame is aborted; 0 disables the timeout.
- `clk` input 1: single system clock; all state changes on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `peripheralClkEdge` input 1: one-`clk`-cycle shift strobe, driven by conditioner `positiveedge`.
- `serialDataIn` input 1: serial data, driven by conditioner `conditioned`.
- `parallelLoad` input 1: synchronous load strobe.
- `parallelDataIn` input `WIDTH`: value loaded when `parallelLoad`=1.
- `parallelDataOut` output `WIDTH`: current register contents.
- `serialDataOut` output 1: register MSB, `parallelDataOut[WIDTH-1]`.
- `bitCount` output clog2(`WIDTH`): bits shifted into the current frame, 0..`WIDTH`-1.
- `frameDone` output 1: one-cycle pulse when a full frame has been shifted in.
- `frameError` output 1: one-cycle pulse when a partial frame is aborted by timeout.

## Operation
- Reset (async, `reset`=1): register=0, `bitCount`=0, idle counter=0, `frameDone`=0, `frameError`=0. All outputs hold these values while reset is asserted. Deassertion takes effect at the next `clk` rising edge.
- Per `clk` edge, priority is load > shift > timeout > hold.
- Load (`parallelLoad`=1):
  - register ← `parallelDataIn`, `bitCount` ← 0, idle counter ← 0.
  - `frameDone` and `frameError` are 0 in the next cycle.
  - A coincident `peripheralClkEdge` is ignored.
- Shift (`peripheralClkEdge`=1, no load):
  - register ← {register[`WIDTH`-2:0], `serialDataIn`}.
  - idle counter ← 0.
  - If `bitCount`=`WIDTH`-1: `bitCount` ← 0 (wrap) and `frameDone` ← 1. Otherwise `bitCount` increments.
- Timeout (no load, no shift, `TIMEOUT`≠0):
  - Idle counter increments and saturates at `TIMEOUT`.
  - On the edge where it reaches `TIMEOUT` with `bitCount`≠0: `bitCount` ← 0 and `frameError` ← 1.
  - Register contents are not cleared.
  - With `bitCount`=0, reaching `TIMEOUT` has no effect.
- `frameDone` and `frameError` are registered. Each is high for exactly one cycle and returns to 0 on the following edge unless re-triggered. They never assert together.
- Back-to-back strobes on consecutive `clk` cycles are legal; each one shifts one bit.

## Timing
- Shift latency: `parallelDataOut`, `serialDataOut` and `bitCount` reflect a strobe one `clk` edge after the cycle in which `peripheralClkEdge`=1.
- `frameDone` rises in the same cycle that `parallelDataOut` first shows the complete frame. The frame stays readable until the next shift or load.
- Load latency: `parallelDataIn` appears on `parallelDataOut` one edge after `parallelLoad`.
- Timeout: `frameError` asserts `TIMEOUT` edges after the last shift strobe's edge.
- Reset mid-frame: the partial frame is discarded and any pending pulse is lost. No `frameDone` or `frameError` is produced for it.
- The upstream conditioner's synchronizer and debounce delay come before this block. This block adds exactly one cycle.

## Test plan
- Reset: assert `reset` mid-operation with register=8'hA5 and `bitCount`=3 → all outputs 0 asynchronously, before the next `clk` edge.
- Frame assembly, `WIDTH`=8: shift in 1,0,1,0,0,1,0,1 on eight strobes → `parallelDataOut`=8'hA5, `bitCount`=0, `frameDone`=1 for exactly one cycle after the 8th strobe.
- Load/shift collision: `parallelLoad`=1 with `parallelDataIn`=8'h3C and `peripheralClkEdge`=1 in the same cycle → `parallelDataOut`=8'h3C, `bitCount`=0. One strobe later with `serialDataIn`=1 → 8'h79, `serialDataOut`=0.
- Timeout, `TIMEOUT`=4: three strobes, then no strobes → `frameError` pulses one cycle, four edges after the last strobe edge, and `bitCount`=0. Repeat with `bitCount`=0 → no pulse.
- Back-to-back frames: 16 strobes on consecutive cycles with data 8'hFF then 8'h00 → two `frameDone` pulses eight cycles apart, showing 8'hFF then 8'h00.
- Serial out: load 8'h81, then apply eight strobes with `serialDataIn`=0 → `serialDataOut` sequence 1,0,0,0,0,0,0,1, then 0.
